// File: rtl/motor_pkg.sv
// motor_pkg: full-scale duty, motor mode encodings and PWM drive codes
// shared by the ramp controller and the PWM stage.
package motor_pkg;
    localparam int MAX_DUTY = 2601;
    localparam logic [11:0] BRAKE_DUTY = 12'hFFF;
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_SPEED = 2'b01,
        MODE_BRAKE = 2'b11
    } mode_e;
    typedef enum logic [1:0] {
        DRV_OFF   = 2'b00,
        DRV_REV   = 2'b01,
        DRV_FWD   = 2'b10,
        DRV_BRAKE = 2'b11
    } drive_e;
endpackage

// File: rtl/motor_ramp_step.sv
// motor_ramp_step: clamps a commanded speed to full scale and computes one
// slew-limited step of a motor's current toward its target.
module motor_ramp_step #(
    parameter int RAMP_STEP = 16,
    parameter int MAX_DUTY  = 2601
) (
    input  logic signed [12:0] speed_i,
    output logic signed [12:0] clamped_o,
    input  logic signed [12:0] target_i,
    input  logic signed [12:0] current_i,
    output logic signed [12:0] next_o
);
    localparam logic signed [12:0] POS  = 13'(MAX_DUTY);
    localparam logic signed [12:0] NEG  = 13'(-MAX_DUTY);
    localparam logic signed [13:0] STEP = 14'(RAMP_STEP);

    logic signed [13:0] diff;
    logic signed [13:0] stepped;
    logic cur_pos, cur_neg, new_pos, new_neg;

    always_comb begin
        clamped_o = speed_i > POS ? POS : speed_i < NEG ? NEG : speed_i;
        diff = 14'(target_i) - 14'(current_i);
        stepped = diff > STEP ? 14'(current_i) + STEP :
                  diff < -STEP ? 14'(current_i) - STEP : 14'(target_i);
        cur_neg = current_i[12];
        cur_pos = !current_i[12] && current_i != '0;
        new_neg = stepped[13];
        new_pos = !stepped[13] && stepped != '0;
        // a step that would flip the direction parks the motor at zero first
        next_o = (cur_pos && new_neg) || (cur_neg && new_pos) ? '0 : stepped[12:0];
    end
endmodule

// File: rtl/motor_cmd_ramp.sv
// motor_cmd_ramp: four-motor command registers with per-tick slew limiting,
// emergency stop and combinational duty/drive-code decode for the PWM stage.
module motor_cmd_ramp #(
    parameter int RAMP_DIV  = 2601,
    parameter int RAMP_STEP = 16,
    parameter int MAX_DUTY  = motor_pkg::MAX_DUTY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_wr,
    input  logic [1:0]         cmd_sel,
    input  logic [1:0]         cmd_mode,
    input  logic signed [12:0] cmd_speed,
    input  logic               estop,
    output logic [11:0]        duty0,
    output logic [11:0]        duty1,
    output logic [11:0]        duty2,
    output logic [11:0]        duty3,
    output logic [7:0]         drive_code,
    output logic [3:0]         at_target,
    output logic               mot_en
);
    import motor_pkg::*;

    localparam int CW = $clog2(RAMP_DIV);

    typedef enum logic {S_WAIT, S_UPD} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    mode_e              mode_q [4];
    mode_e              mode_d [4];
    logic signed [12:0] tgt_q [4];
    logic signed [12:0] tgt_d [4];
    logic signed [12:0] cur_q [4];
    logic signed [12:0] cur_d [4];
    logic               mot_en_q;
    logic               tick;
    logic signed [12:0] clamped, next_cur;
    mode_e              wr_mode;
    logic [11:0]        duty [4];
    logic [1:0]         code [4];

    assign tick = cnt_q == CW'(RAMP_DIV - 1);
    assign wr_mode = cmd_mode == 2'b01 ? MODE_SPEED : cmd_mode == 2'b11 ? MODE_BRAKE : MODE_IDLE;

    motor_ramp_step #(
        .RAMP_STEP(RAMP_STEP),
        .MAX_DUTY (MAX_DUTY)
    ) u_step (
        .speed_i  (cmd_speed),
        .clamped_o(clamped),
        .target_i (tgt_q[idx_q]),
        .current_i(cur_q[idx_q]),
        .next_o   (next_cur)
    );

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        mode_d = mode_q;
        tgt_d = tgt_q;
        cur_d = cur_q;
        if (state_q == S_WAIT) begin
            idx_d = '0;
            state_d = tick ? S_UPD : S_WAIT;
        end else begin
            idx_d = idx_q + 2'd1;
            state_d = idx_q == 2'd3 ? S_WAIT : S_UPD;
            if (mode_q[idx_q] == MODE_SPEED) cur_d[idx_q] = next_cur;
        end
        if (estop) begin
            for (int i = 0; i < 4; i++) begin
                mode_d[i] = MODE_IDLE;
                tgt_d[i] = '0;
                cur_d[i] = '0;
            end
        end else if (cmd_wr) begin
            // a write overrides any update landing on the same motor this cycle
            mode_d[cmd_sel] = wr_mode;
            tgt_d[cmd_sel] = wr_mode == MODE_SPEED ? clamped : '0;
            cur_d[cmd_sel] = wr_mode == MODE_SPEED ? cur_q[cmd_sel] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT;
            cnt_q <= '0;
            idx_q <= '0;
            mot_en_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mode_q[i] <= MODE_IDLE;
                tgt_q[i] <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            mot_en_q <= !estop;
            mode_q <= mode_d;
            tgt_q <= tgt_d;
            cur_q <= cur_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            duty[i] = mode_q[i] == MODE_BRAKE ? BRAKE_DUTY :
                      mode_q[i] == MODE_SPEED ? (cur_q[i][12] ? 12'(-cur_q[i]) : cur_q[i][11:0]) : '0;
            code[i] = mode_q[i] == MODE_BRAKE ? DRV_BRAKE :
                      mode_q[i] != MODE_SPEED || cur_q[i] == '0 ? DRV_OFF :
                      cur_q[i][12] ? DRV_REV : DRV_FWD;
            at_target[i] = cur_q[i] == tgt_q[i];
        end
    end

    assign duty0 = duty[0];
    assign duty1 = duty[1];
    assign duty2 = duty[2];
    assign duty3 = duty[3];
    assign drive_code = {code[0], code[1], code[2], code[3]};
    assign mot_en = mot_en_q;
endmodule

// File: tb/tb_motor_cmd_ramp.sv
// tb_motor_cmd_ramp: directed command sequence checked every cycle against a
// behavioural model, plus hand-computed spot values along the way.
module tb_motor_cmd_ramp;
    localparam int DIV  = 8;
    localparam int STEP = 16;
    localparam int MAXD = 2601;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_wr = 1'b0;
    logic [1:0]         cmd_sel = '0;
    logic [1:0]         cmd_mode = '0;
    logic signed [12:0] cmd_speed = '0;
    logic               estop = 1'b0;
    logic [11:0]        duty0, duty1, duty2, duty3;
    logic [7:0]         drive_code;
    logic [3:0]         at_target;
    logic               mot_en;

    int tests = 0;
    int fails = 0;

    // model: mode 0 idle, 1 speed, 3 brake; e = clock edges since reset released
    int m_mode [4];
    int m_tgt [4];
    int m_cur [4];
    int e = 0;
    bit m_en = 1'b0;

    motor_cmd_ramp #(
        .RAMP_DIV (DIV),
        .RAMP_STEP(STEP),
        .MAX_DUTY (MAXD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_wr    (cmd_wr),
        .cmd_sel   (cmd_sel),
        .cmd_mode  (cmd_mode),
        .cmd_speed (cmd_speed),
        .estop     (estop),
        .duty0     (duty0),
        .duty1     (duty1),
        .duty2     (duty2),
        .duty3     (duty3),
        .drive_code(drive_code),
        .at_target (at_target),
        .mot_en    (mot_en)
    );

    always #5 clk = ~clk;

    function automatic int ramp(int cur, int tgt);
        int n;
        if (tgt - cur > STEP) n = cur + STEP;
        else if (cur - tgt > STEP) n = cur - STEP;
        else n = tgt;
        if (cur * n < 0) n = 0;
        return n;
    endfunction

    // every DIV-th edge is a tick; the four edges after it update motors 0..3
    always @(posedge clk) begin
        int k;
        int v;
        int pre [4];
        if (rst) begin
            e = 0;
            m_en = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 0;
                m_tgt[i] = 0;
                m_cur[i] = 0;
            end
        end else begin
            e = e + 1;
            m_en = !estop;
            pre = m_cur;
            if (e > DIV && (e - 1) % DIV < 4) begin
                k = (e - 1) % DIV;
                if (m_mode[k] == 1) m_cur[k] = ramp(m_cur[k], m_tgt[k]);
            end
            if (estop) begin
                for (int i = 0; i < 4; i++) begin
                    m_mode[i] = 0;
                    m_tgt[i] = 0;
                    m_cur[i] = 0;
                end
            end else if (cmd_wr) begin
                k = int'(cmd_sel);
                if (cmd_mode == 2'b01) begin
                    v = cmd_speed;
                    m_mode[k] = 1;
                    m_tgt[k] = v > MAXD ? MAXD : v < -MAXD ? -MAXD : v;
                    m_cur[k] = pre[k];
                end else begin
                    m_mode[k] = cmd_mode == 2'b11 ? 3 : 0;
                    m_tgt[k] = 0;
                    m_cur[k] = 0;
                end
            end
        end
    end

    function automatic int exp_duty(int i);
        return m_mode[i] == 3 ? 4095 : m_mode[i] == 1 ? (m_cur[i] < 0 ? -m_cur[i] : m_cur[i]) : 0;
    endfunction

    function automatic logic [7:0] exp_code();
        logic [7:0] c;
        logic [1:0] b;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            b = m_mode[i] == 3 ? 2'b11 : m_mode[i] == 1 && m_cur[i] > 0 ? 2'b10 :
                m_mode[i] == 1 && m_cur[i] < 0 ? 2'b01 : 2'b00;
            c = {c[5:0], b};
        end
        return c;
    endfunction

    function automatic logic [3:0] exp_at();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = m_cur[i] == m_tgt[i];
        return a;
    endfunction

    task automatic check(string n, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", n, e, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("model duty0", 32'(duty0), exp_duty(0));
        check("model duty1", 32'(duty1), exp_duty(1));
        check("model duty2", 32'(duty2), exp_duty(2));
        check("model duty3", 32'(duty3), exp_duty(3));
        check("model drive_code", 32'(drive_code), 32'(exp_code()));
        check("model at_target", 32'(at_target), 32'(exp_at()));
        check("model mot_en", 32'(mot_en), 32'(m_en));
    endtask

    task automatic wait_e(int n);
        int b;
        b = 0;
        while (e < n && b < 4000) begin
            step();
            b++;
        end
        check("edge reached", e, n);
    endtask

    task automatic wr(int sel, int mode, int spd);
        cmd_wr = 1'b1;
        cmd_sel = 2'(sel);
        cmd_mode = 2'(mode);
        cmd_speed = 13'(spd);
        step();
        cmd_wr = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check("rst duty0", 32'(duty0), 0);
        check("rst drive_code", 32'(drive_code), 0);
        check("rst at_target", 32'(at_target), 32'hF);
        check("rst mot_en", 32'(mot_en), 0);
        rst = 1'b0;
        step();
        check("mot_en rise", 32'(mot_en), 1);
        wr(0, 1, 40);
        wr(1, 1, 20);
        wr(2, 1, 4000);
        wait_e(9);
        check("m0 tick1", 32'(duty0), 16);
        check("m0 fwd code", 32'(drive_code[7:6]), 2);
        check("m0 not at target", 32'(at_target[0]), 0);
        wait_e(17);
        check("m0 tick2", 32'(duty0), 32);
        wait_e(18);
        check("m1 at +20", 32'(duty1), 20);
        check("m1 at target", 32'(at_target[1]), 1);
        wait_e(20);
        wr(1, 1, -20);
        check("m1 new target", 32'(at_target[1]), 0);
        wait_e(25);
        check("m0 tick3", 32'(duty0), 40);
        check("m0 at target", 32'(at_target[0]), 1);
        wait_e(26);
        check("m1 step 4", 32'(duty1), 4);
        check("m1 code fwd", 32'(drive_code[5:4]), 2);
        wait_e(34);
        check("m1 zero cross", 32'(duty1), 0);
        check("m1 code off", 32'(drive_code[5:4]), 0);
        wait_e(42);
        check("m1 -16", 32'(duty1), 16);
        check("m1 code rev", 32'(drive_code[5:4]), 1);
        wait_e(50);
        check("m1 -20", 32'(duty1), 20);
        check("m1 at target", 32'(at_target[1]), 1);
        wait_e(1306);
        check("m2 2592", 32'(duty2), 2592);
        wait_e(1310);
        check("m2 clamp", 32'(duty2), 2601);
        check("m2 at target", 32'(at_target[2]), 1);
        wr(3, 3, 0);
        check("m3 brake code", 32'(drive_code[1:0]), 3);
        check("m3 brake duty", 32'(duty3), 4095);
        wait_e(1315);
        wr(3, 1, 100);
        check("m3 speed from brake", 32'(duty3), 0);
        wait_e(1339);
        wr(3, 1, -100);
        check("m3 write wins", 32'(duty3), 32);
        check("m3 still fwd", 32'(drive_code[1:0]), 2);
        wait_e(1348);
        check("m3 toward new target", 32'(duty3), 16);
        wait_e(1349);
        check("mot_en before estop", 32'(mot_en), 1);
        estop = 1'b1;
        step();
        check("estop codes", 32'(drive_code), 0);
        check("estop duty2", 32'(duty2), 0);
        check("estop mot_en", 32'(mot_en), 0);
        wr(0, 1, 500);
        check("estop write ignored", 32'(duty0), 0);
        wait_e(1360);
        check("estop at_target", 32'(at_target), 32'hF);
        estop = 1'b0;
        step();
        check("mot_en after estop", 32'(mot_en), 1);
        wr(0, 1, 100);
        wr(1, 1, -100);
        wait_e(1370);
        check("post estop m0", 32'(duty0), 16);
        check("post estop m1", 32'(duty1), 16);
        check("post estop codes", 32'(drive_code), 32'h90);
        wait_e(1377);
        rst = 1'b1;
        step();
        check("mid rst duty0", 32'(duty0), 0);
        check("mid rst codes", 32'(drive_code), 0);
        check("mid rst at_target", 32'(at_target), 32'hF);
        check("mid rst mot_en", 32'(mot_en), 0);
        step();
        rst = 1'b0;
        repeat (30) step();
        check("ramp discarded m0", 32'(duty0), 0);
        check("ramp discarded m1", 32'(duty1), 0);
        check("idle at_target", 32'(at_target), 32'hF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/motor_cmd_ramp.md
MOTOR_CMD_RAMP -- requirements
Module: motor_cmd_ramp

Interface
REQ-001 Parameter RAMP_DIV, default 2601: clk cycles between ramp ticks (one PWM period); legal range >= 8.
REQ-002 Parameter RAMP_STEP, default 16: max change of |current| per motor per tick; legal range 1..255.
REQ-003 Parameter MAX_DUTY, default 2601: full-scale magnitude (100% duty).
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk  in  1  system clock.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port cmd_wr  in  1  command write strobe, one-cycle pulse.
REQ-008 Port cmd_sel  in  2  motor index 0..3.
REQ-009 Port cmd_mode  in  2  00 idle, 01 speed, 11 brake, 10 treated as idle.
REQ-010 Port cmd_speed  in  13  signed two's-complement target speed.
REQ-011 Port estop  in  1  emergency stop, level.
REQ-012 Port duty0..duty3  out  12 each  per-motor duty to the PWM stage.
REQ-013 Port drive_code  out  8  [7:6] motor0 top/bot ... [1:0] motor3 top/bot.
REQ-014 Port at_target  out  4  bit i set when motor i current equals its target.
REQ-015 Port mot_en  out  1  global motor enable to the PWM stage.

Function
REQ-016 Per-motor state: mode (2b), target (13b signed), current (13b signed).
REQ-017 Speed-mode write stores target = cmd_speed clamped to [-MAX_DUTY, +MAX_DUTY]; e.g. -4096 -> -2601.
REQ-018 Idle or brake write sets mode, target = 0, current = 0 on the write edge.
REQ-019 Tick counter counts 0..RAMP_DIV-1, wraps to 0; tick asserted on the wrap cycle.
REQ-020 FSM states S_WAIT, S_UPD; S_WAIT -> S_UPD on tick with idx = 0; S_UPD updates motor idx, idx++ each cycle; after idx 3 -> S_WAIT.
REQ-021 Update (speed mode): |target-current| <= RAMP_STEP -> current = target; else current moves RAMP_STEP toward target.
REQ-022 Zero crossing: a step that would change the sign of current yields current = 0 for that update.
REQ-023 Write to motor idx in the same cycle as its update: write wins; update uses the pre-write target and is discarded.
REQ-024 Outputs decoded combinationally from state registers; no added latency.
REQ-025 Speed mode: duty = |current|; code 10 if current > 0, 01 if < 0, 00 with duty 0 if = 0.
REQ-026 Brake mode: code 11, duty = 4095. Idle mode: code 00, duty 0.
REQ-027 at_target[i] = (current == target), so always 1 in idle/brake.
REQ-028 estop high: every motor forced idle with target/current 0 each cycle; writes ignored; FSM and tick counter keep running.
REQ-029 mot_en registered: mot_en <= !estop, one-cycle latency.

Reset
REQ-030 On rst: all modes idle, targets/currents 0, tick counter 0, FSM S_WAIT, idx 0, mot_en 0.
REQ-031 Resulting outputs: duty0..3 = 0, drive_code = 0, at_target = 4'hF; mot_en = 1 on the first cycle after rst falls if estop is low.
REQ-032 rst mid-ramp or mid-S_UPD aborts the update; pending ramps are discarded.

Structure
REQ-033 Shared package motor_pkg holds MAX_DUTY, mode encodings (IDLE/SPEED/BRAKE) and drive codes (FWD 10, REV 01, BRAKE 11, OFF 00); the PWM stage imports it too.
REQ-034 Sub-module motor_ramp_step: combinational next-current (clamp, step, zero-crossing); one instance shared across motors by the idx mux.

Verification (RAMP_DIV = 8, RAMP_STEP = 16)
REQ-035 Reset -> duty all 0, drive_code 00h, at_target Fh, mot_en 0 during rst and 1 one cycle after.
REQ-036 Write m0 speed +40 -> current 16, 32, 40 on successive ticks; drive_code[7:6] = 10; at_target[0] rises at the third update.
REQ-037 m1 at +20, write -20 -> current 4, 0 (code 00), -16, -20 (code 01); no single step changes sign.
REQ-038 Write m2 speed +4000 -> target 2601; duty2 reaches 2601 and never exceeds it.
REQ-039 Brake write m3 -> drive_code[1:0] = 11 and duty3 = 4095 on the write edge; write coincident with its update -> write value wins.
REQ-040 estop high mid-ramp -> all duty/codes 0 on the next edge, mot_en 0 one cycle later, writes ignored; rst mid-ramp -> REQ-030 state.
